// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared types and helpers for the Decode-stage operand fetch.
//   reg_addr_t   - architectural register address
//   fwd_sel_t    - operand source selection (zero, Execute, Memory, Writeback, register file)
//   REG_ZERO     - hardwired-zero register address
//   fwd_select   - youngest-producer-wins source selection for one operand
//   load_hazard  - load-use hazard detection for one operand
package operand_fetch_pkg;

  localparam int unsigned REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_E,
    FWD_M,
    FWD_W,
    FWD_RF
  } fwd_sel_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // we_w must already be gated by the halt condition.
  function automatic fwd_sel_t fwd_select(
    input reg_addr_t r,
    input logic      we_e,
    input reg_addr_t rd_e,
    input logic      ld_e,
    input logic      we_m,
    input reg_addr_t rd_m,
    input logic      ld_m,
    input logic      we_w,
    input reg_addr_t rd_w
  );
    if (r == REG_ZERO)                   return FWD_ZERO;
    else if (we_e && rd_e == r && !ld_e) return FWD_E;
    else if (we_m && rd_m == r && !ld_m) return FWD_M;
    else if (we_w && rd_w == r)          return FWD_W;
    else                                 return FWD_RF;
  endfunction

  function automatic logic load_hazard(
    input logic      valid,
    input logic      used,
    input reg_addr_t r,
    input logic      we_e,
    input reg_addr_t rd_e,
    input logic      ld_e,
    input logic      we_m,
    input reg_addr_t rd_m,
    input logic      ld_m
  );
    return valid && used && (r != REG_ZERO) &&
           ((we_e && rd_e == r && ld_e) || (we_m && rd_m == r && ld_m));
  endfunction

endpackage

// File: rtl/operand_fetch_register_file.sv
// register_file: architectural register file with x0 hardwired to zero.
//   clk, rst_l      - clock, synchronous active-low reset (clears all entries)
//   raddr1/raddr2   - asynchronous read addresses
//   rdata1/rdata2   - read data (0 for address 0)
//   we/waddr/wdata  - synchronous write port; writes to address 0 are dropped
module register_file
  import operand_fetch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: Decode-side register read with RAW forwarding, load-use
// stall generation and the D/E operand pipeline register.
//   clk, rst_l                      - clock, synchronous active-low reset
//   rs1_D, rs2_D, rs*_used_D        - Decode source registers and their use flags
//   valid_D                         - Decode holds a real instruction
//   rd_*, rd_we_*, is_load_*        - in-flight producers in Execute/Memory/Writeback
//   alu_result_E/M, rd_data_W       - forwardable results; rd_data_W is also the RF write data
//   stall_E, flush_E                - D/E hold and squash
//   halt_W                          - freezes the register file until reset
//   stall_D                         - load-use stall (combinational)
//   rs1_data_E, rs2_data_E, valid_E - registered resolved operands
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic [4:0]      rs1_D,
  input  logic [4:0]      rs2_D,
  input  logic            rs1_used_D,
  input  logic            rs2_used_D,
  input  logic            valid_D,
  input  logic [4:0]      rd_E,
  input  logic [4:0]      rd_M,
  input  logic [4:0]      rd_W,
  input  logic            rd_we_E,
  input  logic            rd_we_M,
  input  logic            rd_we_W,
  input  logic            is_load_E,
  input  logic            is_load_M,
  input  logic [XLEN-1:0] alu_result_E,
  input  logic [XLEN-1:0] alu_result_M,
  input  logic [XLEN-1:0] rd_data_W,
  input  logic            stall_E,
  input  logic            flush_E,
  input  logic            halt_W,
  output logic            stall_D,
  output logic [XLEN-1:0] rs1_data_E,
  output logic [XLEN-1:0] rs2_data_E,
  output logic            valid_E
);

  localparam int unsigned AW = $clog2(NREGS);

  // Once a halt reaches Writeback the register file stays frozen until reset,
  // even if halt_W itself drops afterwards.
  logic halted;
  logic wb_we;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      halted <= 1'b0;
    end else if (halt_W) begin
      halted <= 1'b1;
    end
  end

  assign wb_we = rd_we_W && !halt_W && !halted;

  logic [XLEN-1:0] rf_rdata1, rf_rdata2;

  register_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_register_file (
    .clk    (clk),
    .rst_l  (rst_l),
    .raddr1 (rs1_D[AW-1:0]),
    .raddr2 (rs2_D[AW-1:0]),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (wb_we),
    .waddr  (rd_W[AW-1:0]),
    .wdata  (rd_data_W)
  );

  fwd_sel_t        sel1, sel2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            haz1, haz2;

  always_comb begin
    sel1 = fwd_select(rs1_D, rd_we_E, rd_E, is_load_E, rd_we_M, rd_M, is_load_M, wb_we, rd_W);
    sel2 = fwd_select(rs2_D, rd_we_E, rd_E, is_load_E, rd_we_M, rd_M, is_load_M, wb_we, rd_W);

    rs1_val = '0;
    case (sel1)
      FWD_E:   rs1_val = alu_result_E;
      FWD_M:   rs1_val = alu_result_M;
      FWD_W:   rs1_val = rd_data_W;
      FWD_RF:  rs1_val = rf_rdata1;
      default: rs1_val = '0;
    endcase

    rs2_val = '0;
    case (sel2)
      FWD_E:   rs2_val = alu_result_E;
      FWD_M:   rs2_val = alu_result_M;
      FWD_W:   rs2_val = rd_data_W;
      FWD_RF:  rs2_val = rf_rdata2;
      default: rs2_val = '0;
    endcase

    haz1 = load_hazard(valid_D, rs1_used_D, rs1_D, rd_we_E, rd_E, is_load_E,
                       rd_we_M, rd_M, is_load_M);
    haz2 = load_hazard(valid_D, rs2_used_D, rs2_D, rd_we_E, rd_E, is_load_E,
                       rd_we_M, rd_M, is_load_M);
  end

  assign stall_D = haz1 || haz2;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      rs1_data_E <= '0;
      rs2_data_E <= '0;
      valid_E    <= 1'b0;
    end else if (stall_E) begin
      rs1_data_E <= rs1_data_E;
      rs2_data_E <= rs2_data_E;
      valid_E    <= valid_E;
    end else if (flush_E || stall_D) begin
      rs1_data_E <= '0;
      rs2_data_E <= '0;
      valid_E    <= 1'b0;
    end else begin
      rs1_data_E <= rs1_val;
      rs2_data_E <= rs2_val;
      valid_E    <= valid_D;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed self-checking bench for operand_fetch.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [4:0]  rs1_D, rs2_D, rd_E, rd_M, rd_W;
  logic        rs1_used_D, rs2_used_D, valid_D;
  logic        rd_we_E, rd_we_M, rd_we_W, is_load_E, is_load_M;
  logic [31:0] alu_result_E, alu_result_M, rd_data_W;
  logic        stall_E, flush_E, halt_W;
  logic        stall_D, valid_E;
  logic [31:0] rs1_data_E, rs2_data_E;

  int checks   = 0;
  int failures = 0;

  operand_fetch #(.XLEN(32), .NREGS(32)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .rs1_D        (rs1_D),
    .rs2_D        (rs2_D),
    .rs1_used_D   (rs1_used_D),
    .rs2_used_D   (rs2_used_D),
    .valid_D      (valid_D),
    .rd_E         (rd_E),
    .rd_M         (rd_M),
    .rd_W         (rd_W),
    .rd_we_E      (rd_we_E),
    .rd_we_M      (rd_we_M),
    .rd_we_W      (rd_we_W),
    .is_load_E    (is_load_E),
    .is_load_M    (is_load_M),
    .alu_result_E (alu_result_E),
    .alu_result_M (alu_result_M),
    .rd_data_W    (rd_data_W),
    .stall_E      (stall_E),
    .flush_E      (flush_E),
    .halt_W       (halt_W),
    .stall_D      (stall_D),
    .rs1_data_E   (rs1_data_E),
    .rs2_data_E   (rs2_data_E),
    .valid_E      (valid_E)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pipe();
    rd_E = '0; rd_M = '0; rd_W = '0;
    rd_we_E = 0; rd_we_M = 0; rd_we_W = 0;
    is_load_E = 0; is_load_M = 0;
    alu_result_E = '0; alu_result_M = '0; rd_data_W = '0;
    stall_E = 0; flush_E = 0;
  endtask

  task automatic test_reset();
    rst_l = 0; halt_W = 0;
    rs1_D = '0; rs2_D = '0; rs1_used_D = 0; rs2_used_D = 0; valid_D = 0;
    clear_pipe();
    step(); step();
    checks++;
    if (valid_E !== 1'b0) begin
      failures++; $display("FAIL reset_valid_E got=%0b exp=0", valid_E);
    end
    checks++;
    if (rs1_data_E !== 32'h0 || rs2_data_E !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h exp=0/0", rs1_data_E, rs2_data_E);
    end
    // A load hazard pattern with an invalid Decode instruction must not stall.
    rd_E = 5'd4; rd_we_E = 1; is_load_E = 1; rs1_D = 5'd4; rs1_used_D = 1;
    #1;
    checks++;
    if (stall_D !== 1'b0) begin
      failures++; $display("FAIL reset_invalid_no_stall got=%0b exp=0", stall_D);
    end
    clear_pipe();
    rst_l = 1;
  endtask

  task automatic test_write_through();
    valid_D = 1; rs1_D = 5'd5; rs1_used_D = 1; rs2_D = 5'd0; rs2_used_D = 0;
    rd_we_W = 1; rd_W = 5'd5; rd_data_W = 32'hDEAD_BEEF;
    step();
    checks++;
    if (rs1_data_E !== 32'hDEAD_BEEF || valid_E !== 1'b1) begin
      failures++;
      $display("FAIL write_through got=%h v=%0b exp=deadbeef v=1", rs1_data_E, valid_E);
    end
    clear_pipe();
    step();
    checks++;
    if (rs1_data_E !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL rf_read_x5 got=%h exp=deadbeef", rs1_data_E);
    end
  endtask

  task automatic test_x0_guard();
    rs1_D = 5'd0; rs2_D = 5'd0; rs1_used_D = 1; rs2_used_D = 1;
    rd_we_W = 1; rd_W = 5'd0; rd_data_W = 32'h1234;
    step();
    checks++;
    if (rs1_data_E !== 32'h0 || rs2_data_E !== 32'h0) begin
      failures++;
      $display("FAIL x0_write_through got=%h/%h exp=0/0", rs1_data_E, rs2_data_E);
    end
    clear_pipe();
    step();
    checks++;
    if (rs1_data_E !== 32'h0) begin
      failures++; $display("FAIL x0_after_write got=%h exp=0", rs1_data_E);
    end
  endtask

  task automatic test_forward_priority();
    rs1_D = 5'd0; rs1_used_D = 0; rs2_D = 5'd7; rs2_used_D = 1;
    rd_E = 5'd7; rd_we_E = 1; alu_result_E = 32'h11;
    rd_M = 5'd7; rd_we_M = 1; alu_result_M = 32'h22;
    rd_W = 5'd7; rd_we_W = 1; rd_data_W    = 32'h33;
    step();
    checks++;
    if (rs2_data_E !== 32'h11) begin
      failures++; $display("FAIL fwd_all_three got=%h exp=00000011", rs2_data_E);
    end
    rd_we_E = 0;
    step();
    checks++;
    if (rs2_data_E !== 32'h22) begin
      failures++; $display("FAIL fwd_m_over_w got=%h exp=00000022", rs2_data_E);
    end
    rd_we_M = 0;
    step();
    checks++;
    if (rs2_data_E !== 32'h33) begin
      failures++; $display("FAIL fwd_w_only got=%h exp=00000033", rs2_data_E);
    end
    clear_pipe();
    step();
    checks++;
    if (rs2_data_E !== 32'h33) begin
      failures++; $display("FAIL rf_read_x7 got=%h exp=00000033", rs2_data_E);
    end
  endtask

  task automatic test_load_use();
    rs1_D = 5'd3; rs1_used_D = 1; rs2_D = 5'd0; rs2_used_D = 0; valid_D = 1;
    rd_E = 5'd3; rd_we_E = 1; is_load_E = 1; alu_result_E = 32'hBAD0;
    #1;
    checks++;
    if (stall_D !== 1'b1) begin
      failures++; $display("FAIL load_use_stall_E got=%0b exp=1", stall_D);
    end
    step();
    checks++;
    if (valid_E !== 1'b0 || rs1_data_E !== 32'h0) begin
      failures++;
      $display("FAIL load_use_bubble1 got v=%0b d=%h exp v=0 d=0", valid_E, rs1_data_E);
    end
    clear_pipe();
    rd_M = 5'd3; rd_we_M = 1; is_load_M = 1; alu_result_M = 32'hBAD1;
    #1;
    checks++;
    if (stall_D !== 1'b1) begin
      failures++; $display("FAIL load_use_stall_M got=%0b exp=1", stall_D);
    end
    step();
    checks++;
    if (valid_E !== 1'b0) begin
      failures++; $display("FAIL load_use_bubble2 got v=%0b exp v=0", valid_E);
    end
    clear_pipe();
    rd_W = 5'd3; rd_we_W = 1; rd_data_W = 32'hCAFE;
    #1;
    checks++;
    if (stall_D !== 1'b0) begin
      failures++; $display("FAIL load_use_released got=%0b exp=0", stall_D);
    end
    step();
    checks++;
    if (rs1_data_E !== 32'hCAFE || valid_E !== 1'b1) begin
      failures++;
      $display("FAIL load_use_data got=%h v=%0b exp=0000cafe v=1", rs1_data_E, valid_E);
    end
    clear_pipe();
    // Unused source register never stalls.
    rs1_used_D = 0; rd_E = 5'd3; rd_we_E = 1; is_load_E = 1;
    #1;
    checks++;
    if (stall_D !== 1'b0) begin
      failures++; $display("FAIL unused_src_no_stall got=%0b exp=0", stall_D);
    end
    clear_pipe();
  endtask

  task automatic test_hold_flush();
    valid_D = 1; rs1_D = 5'd5; rs1_used_D = 1; rs2_D = 5'd7; rs2_used_D = 1;
    step();
    checks++;
    if (rs1_data_E !== 32'hDEAD_BEEF || rs2_data_E !== 32'h33) begin
      failures++;
      $display("FAIL hold_setup got=%h/%h exp=deadbeef/00000033", rs1_data_E, rs2_data_E);
    end
    stall_E = 1; valid_D = 0; rs1_D = 5'd0; rs2_D = 5'd0;
    rd_we_W = 1; rd_W = 5'd10; rd_data_W = 32'hA5A5;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rs1_data_E !== 32'hDEAD_BEEF || rs2_data_E !== 32'h33 || valid_E !== 1'b1) begin
        failures++;
        $display("FAIL hold_cycle%0d got=%h/%h v=%0b exp=deadbeef/00000033 v=1",
                 i, rs1_data_E, rs2_data_E, valid_E);
      end
    end
    clear_pipe();
    valid_D = 1; rs1_D = 5'd10; rs2_D = 5'd0;
    step();
    checks++;
    if (rs1_data_E !== 32'hA5A5) begin
      failures++; $display("FAIL write_during_hold got=%h exp=0000a5a5", rs1_data_E);
    end
    rd_E = 5'd10; rd_we_E = 1; is_load_E = 1; flush_E = 1;
    step();
    checks++;
    if (valid_E !== 1'b0 || rs1_data_E !== 32'h0) begin
      failures++;
      $display("FAIL flush_with_stall got v=%0b d=%h exp v=0 d=0", valid_E, rs1_data_E);
    end
    clear_pipe();
  endtask

  task automatic test_halt_reset();
    valid_D = 1; rs1_D = 5'd9; rs1_used_D = 1; rs2_D = 5'd0; rs2_used_D = 0;
    rd_we_W = 1; rd_W = 5'd9; rd_data_W = 32'h99;
    step();
    checks++;
    if (rs1_data_E !== 32'h99) begin
      failures++; $display("FAIL halt_setup got=%h exp=00000099", rs1_data_E);
    end
    halt_W = 1; rd_data_W = 32'h77;
    step();
    checks++;
    if (rs1_data_E !== 32'h99) begin
      failures++; $display("FAIL halt_no_forward got=%h exp=00000099", rs1_data_E);
    end
    rd_we_W = 0;
    step();
    checks++;
    if (rs1_data_E !== 32'h99 || valid_E !== 1'b1) begin
      failures++;
      $display("FAIL halt_rf_frozen got=%h v=%0b exp=00000099 v=1", rs1_data_E, valid_E);
    end
    // Reset in the middle of a load-use stall.
    rs1_D = 5'd3; rd_E = 5'd3; rd_we_E = 1; is_load_E = 1;
    #1;
    checks++;
    if (stall_D !== 1'b1) begin
      failures++; $display("FAIL pre_reset_stall got=%0b exp=1", stall_D);
    end
    rst_l = 0;
    step();
    checks++;
    if (valid_E !== 1'b0 || rs1_data_E !== 32'h0 || rs2_data_E !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_stall got v=%0b d=%h/%h exp v=0 d=0/0",
               valid_E, rs1_data_E, rs2_data_E);
    end
    rst_l = 1; halt_W = 0;
    clear_pipe();
    rs1_D = 5'd9;
    step();
    checks++;
    if (rs1_data_E !== 32'h0 || valid_E !== 1'b1) begin
      failures++;
      $display("FAIL x9_after_reset got=%h v=%0b exp=0 v=1", rs1_data_E, valid_E);
    end
  endtask

  initial begin
    test_reset();
    test_write_through();
    test_x0_guard();
    test_forward_priority();
    test_load_use();
    test_hold_flush();
    test_halt_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
